hangman_host_ctrl: RTL and testbench
====================================

// Module: hangman_host_ctrl
// PURPOSE
//  Host/player-side driver for the hangman game engine. It collects the 5-letter secret word
//  from the keypad byte stream and presents it on setWord. It then pulses toggle_state to start
//  the game and issues validated player guesses on guess. Guess issue is paced by the engine's
//  red_busy/game_rdy handshake. It watches correct/incorrect to detect game end, and pulses
//  gameEnd on restart.
// PARAMETERS
//  WORD_LEN  5    letters per word; setWord width = 8*WORD_LEN
//  MAX_MISS  6    incorrect count that ends the game
//  TIMEOUT   255  max cycles in WAIT before timeout_err; counter width = $clog2(TIMEOUT+1)
// PORTS
//  clk            in   1   system clock
//  rst            in   1   asynchronous reset, active-high
//  key_data       in   8   ASCII byte from keypad/UART
//  key_valid      in   1   1-cycle strobe, key_data valid
//  word_submit    in   1   host confirms loaded word
//  new_game       in   1   abort/restart request
//  game_rdy       in   1   engine ready for start/guess
//  red_busy       in   1   engine evaluating a guess
//  correct        in   3   engine correct-letter count
//  incorrect      in   3   engine miss count
//  setWord        out  40  secret word; first letter in [39:32]
//  toggle_state   out  1   1-cycle start pulse to engine
//  guess          out  8   current guess; 0 = no guess
//  gameEnd        out  1   1-cycle end/restart pulse to engine
//  letters_loaded out  3   letters shifted into setWord (0..WORD_LEN)
//  reject         out  1   1-cycle pulse: key or submit refused
//  timeout_err    out  1   1-cycle pulse: engine failed to complete handshake
//  phase          out  3   current FSM state (debug/LCD)
// BEHAVIOUR
//  Reset: all outputs 0; state LOAD; counters and history cleared. All outputs registered.
//  Valid letter: 'A'..'Z' (0x41..0x5A). Lowercase 0x61..0x7A is folded to upper case before
//   the check. Anything else -> reject=1 the next cycle, no other effect.
//  LOAD:
//   - Valid key with letters_loaded<5: setWord<={setWord[31:0],key}, letters_loaded++.
//   - Key with letters_loaded==5: reject.
//   - word_submit with letters_loaded<5: reject.
//   - word_submit with letters_loaded==5 -> ARM.
//   - key_valid and word_submit in the same cycle: key processed, submit ignored.
//  ARM: wait for game_rdy=1. Then toggle_state=1 for exactly 1 cycle -> PLAY. setWord is frozen
//   from ARM until the next LOAD.
//  PLAY: on valid key with game_rdy=1 -> guess<=letter, tmo counter cleared -> WAIT.
//   - Key while game_rdy=0 -> reject.
//   - Repeat letter -> reject; guess unchanged (see CONFIGURATION).
//  WAIT: guess held stable.
//   - Set seen_busy when red_busy=1.
//   - seen_busy and game_rdy=1 -> DONE if correct==WORD_LEN or incorrect==MAX_MISS, else PLAY.
//   - tmo reaches TIMEOUT -> timeout_err pulse -> PLAY, guess unchanged.
//   - Keys in WAIT -> reject.
//  DONE: keys rejected. Wait for new_game.
//  new_game (any state, highest priority):
//   - Next cycle: gameEnd=1 for 1 cycle if state was ARM/PLAY/WAIT/DONE.
//   - guess<=0, setWord<=0, letters_loaded<=0, history cleared -> LOAD.
//   - new_game in LOAD: clears only, no gameEnd pulse.
//  Simultaneous new_game + key_valid: key dropped, no reject.
//  Reset mid-game: immediate return to reset values; no gameEnd pulse.
//  At most one of toggle_state/gameEnd/reject/timeout_err may be high per cycle; priority order:
//   gameEnd, toggle_state, timeout_err, reject.
// CONFIGURATION
//  GUESS_HISTORY_EN defined:
//   - 26-bit used-letter mask, set on each issued guess, cleared on new_game/reset.
//   - Any previously guessed letter -> reject.
//  GUESS_HISTORY_EN undefined:
//   - No mask; only a letter equal to the current guess is rejected, because the engine
//     ignores an unchanged guess.
// STRUCTURE
//  hangman_pkg: host_state_t {LOAD,ARM,PLAY,WAIT,DONE}, ASCII_A=8'h41, ASCII_Z=8'h5A,
//   CASE_BIT=8'h20, WIN_COUNT, MISS_LIMIT.
//  Sub-module letter_filter: combinational case-fold, range check, repeat check (history mask
//   under GUESS_HISTORY_EN); outputs letter_ok, letter_norm[7:0].
// TESTING
//  1. Keys H,E,L,L,O then submit, game_rdy=1 -> setWord=40'h48454C4C4F; one toggle_state pulse;
//     phase=PLAY.
//  2. Keys 'a','1' in LOAD -> letters_loaded=1, setWord[7:0]=8'h41; reject pulses once (for '1').
//     Submit at 4 letters -> reject.
//  3. PLAY, key 'E' -> guess=8'h45. Model red_busy 5 cycles then game_rdy -> back to PLAY.
//     Key 'E' again -> reject, guess unchanged.
//  4. GUESS_HISTORY_EN: guess A, B, then A -> third rejected. Without the macro, the third A is
//     accepted.
//  5. WAIT with red_busy never asserted -> timeout_err after exactly TIMEOUT cycles; phase=PLAY.
//  6. incorrect reaches 6 after handshake -> DONE, keys rejected. new_game -> gameEnd 1 cycle,
//     guess=0, phase=LOAD. rst asserted mid-WAIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman host-side controller.
// The GUESS_HISTORY_EN macro is used by the files that import this package.
package hangman_pkg;

  typedef enum logic [2:0] {
    LOAD = 3'd0,
    ARM  = 3'd1,
    PLAY = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } host_state_t;

  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_Z  = 8'h5A;
  localparam logic [7:0] CASE_BIT = 8'h20;
  localparam int         WIN_COUNT  = 5;
  localparam int         MISS_LIMIT = 6;

endpackage

// File: rtl/letter_filter.sv
// Combinational key screening: case fold, A..Z range check, repeat-guess check.
// GUESS_HISTORY_EN: repeats are checked against the 26-bit used-letter mask.
module letter_filter
  import hangman_pkg::*;
(
  input  logic [7:0]  key,
  input  logic [7:0]  cur_guess,
`ifdef GUESS_HISTORY_EN
  input  logic [25:0] history,
`endif
  output logic [7:0]  letter_norm,
  output logic        letter_ok,
  output logic        repeat_hit
);

  always_comb begin
    letter_norm = key;
    if (key >= (ASCII_A | CASE_BIT) && key <= (ASCII_Z | CASE_BIT))
      letter_norm = key & ~CASE_BIT;
    letter_ok = (letter_norm >= ASCII_A) && (letter_norm <= ASCII_Z);
  end

`ifdef GUESS_HISTORY_EN
  logic [4:0] idx;
  assign idx        = 5'(letter_norm - ASCII_A);
  assign repeat_hit = letter_ok && (history[idx] || letter_norm == cur_guess);
`else
  // Engine ignores an unchanged guess, so only the current one counts as a repeat.
  assign repeat_hit = letter_ok && (letter_norm == cur_guess);
`endif

endmodule

// File: rtl/hangman_host_ctrl.sv
// Host/player driver for the hangman engine: word load, start, paced guesses, end pulse.
// Optional GUESS_HISTORY_EN rejects any letter guessed earlier in the current game.
module hangman_host_ctrl
  import hangman_pkg::*;
#(
  parameter int WORD_LEN = WIN_COUNT,
  parameter int MAX_MISS = MISS_LIMIT,
  parameter int TIMEOUT  = 255
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            key_data,
  input  logic                  key_valid,
  input  logic                  word_submit,
  input  logic                  new_game,
  input  logic                  game_rdy,
  input  logic                  red_busy,
  input  logic [2:0]            correct,
  input  logic [2:0]            incorrect,
  output logic [8*WORD_LEN-1:0] setWord,
  output logic                  toggle_state,
  output logic [7:0]            guess,
  output logic                  gameEnd,
  output logic [2:0]            letters_loaded,
  output logic                  reject,
  output logic                  timeout_err,
  output logic [2:0]            phase
);

  localparam int TW = $clog2(TIMEOUT + 1);

  host_state_t   state;
  logic [TW-1:0] tmo;
  logic          seen_busy;
  logic [7:0]    letter_norm;
  logic          letter_ok, repeat_hit;
  logic          full, hs_done, tmo_hit, game_over;

`ifdef GUESS_HISTORY_EN
  logic [25:0] history;
`endif

  letter_filter u_filter (
    .key         (key_data),
    .cur_guess   (guess),
`ifdef GUESS_HISTORY_EN
    .history     (history),
`endif
    .letter_norm (letter_norm),
    .letter_ok   (letter_ok),
    .repeat_hit  (repeat_hit)
  );

  assign phase     = state;
  assign full      = (letters_loaded == 3'(WORD_LEN));
  assign hs_done   = seen_busy && game_rdy;
  assign tmo_hit   = (tmo == TW'(TIMEOUT - 1));
  assign game_over = (correct == 3'(WORD_LEN)) || (incorrect == 3'(MAX_MISS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= LOAD;
      setWord        <= '0;
      guess          <= '0;
      letters_loaded <= '0;
      toggle_state   <= 1'b0;
      gameEnd        <= 1'b0;
      reject         <= 1'b0;
      timeout_err    <= 1'b0;
      tmo            <= '0;
      seen_busy      <= 1'b0;
`ifdef GUESS_HISTORY_EN
      history        <= '0;
`endif
    end else begin
      toggle_state <= 1'b0;
      gameEnd      <= 1'b0;
      reject       <= 1'b0;
      timeout_err  <= 1'b0;
      // new_game overrides everything, including a key presented in the same cycle
      if (new_game) begin
        gameEnd        <= (state != LOAD);
        state          <= LOAD;
        setWord        <= '0;
        guess          <= '0;
        letters_loaded <= '0;
        tmo            <= '0;
        seen_busy      <= 1'b0;
`ifdef GUESS_HISTORY_EN
        history        <= '0;
`endif
      end else begin
        unique case (state)
          LOAD: begin
            if (key_valid) begin
              if (letter_ok && !full) begin
                setWord        <= {setWord[8*WORD_LEN-9:0], letter_norm};
                letters_loaded <= letters_loaded + 3'd1;
              end else begin
                reject <= 1'b1;
              end
            end else if (word_submit) begin
              if (full) state  <= ARM;
              else      reject <= 1'b1;
            end
          end
          ARM: begin
            if (game_rdy) begin
              toggle_state <= 1'b1;
              state        <= PLAY;
            end else begin
              reject <= key_valid;
            end
          end
          PLAY: begin
            if (key_valid) begin
              if (letter_ok && !repeat_hit && game_rdy) begin
                guess     <= letter_norm;
                tmo       <= '0;
                seen_busy <= 1'b0;
                state     <= WAIT;
`ifdef GUESS_HISTORY_EN
                history   <= history | (26'd1 << 5'(letter_norm - ASCII_A));
`endif
              end else begin
                reject <= 1'b1;
              end
            end
          end
          WAIT: begin
            seen_busy <= seen_busy | red_busy;
            if (hs_done) begin
              state <= game_over ? DONE : PLAY;
            end else if (tmo_hit) begin
              timeout_err <= 1'b1;
              state       <= PLAY;
            end else begin
              tmo <= tmo + 1'b1;
            end
            // timeout_err outranks reject when both would fire
            reject <= key_valid && (hs_done || !tmo_hit);
          end
          DONE: reject <= key_valid;
          default: state <= LOAD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hangman_host_ctrl.sv
// Scoreboard bench for hangman_host_ctrl: directed scenarios plus randomized traffic
// checked cycle by cycle against a behavioural model of the host rules.
`timescale 1ns/1ps
module tb_hangman_host_ctrl;

  localparam int TIMEOUT = 255;
  localparam int P_LOAD = 0, P_ARM = 1, P_PLAY = 2, P_WAIT = 3, P_DONE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  key_data = '0;
  logic        key_valid = 1'b0, word_submit = 1'b0, new_game = 1'b0;
  logic        game_rdy = 1'b0, red_busy = 1'b0;
  logic [2:0]  correct = '0, incorrect = '0;
  logic [39:0] setWord;
  logic        toggle_state, gameEnd, reject, timeout_err;
  logic [7:0]  guess;
  logic [2:0]  letters_loaded, phase;

  hangman_host_ctrl #(.WORD_LEN(5), .MAX_MISS(6), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .key_data(key_data), .key_valid(key_valid),
    .word_submit(word_submit), .new_game(new_game), .game_rdy(game_rdy),
    .red_busy(red_busy), .correct(correct), .incorrect(incorrect),
    .setWord(setWord), .toggle_state(toggle_state), .guess(guess),
    .gameEnd(gameEnd), .letters_loaded(letters_loaded), .reject(reject),
    .timeout_err(timeout_err), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          now;
    int unsigned cyc;
    bit          ge, tg, te, rj;
    logic [7:0]  guess;
    logic [39:0] word;
    logic [2:0]  nl, ph;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  event        chk_ev;
  int unsigned cyc = 0;
  int          tests = 0, fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // engine-side values applied with the next drive
  logic       e_rdy = 1'b0, e_busy = 1'b0;
  logic [2:0] e_cor = '0, e_inc = '0;

  // behavioural model of the host
  int         m_ph;
  byte        m_word[$];
  logic [7:0] m_guess;
  bit [25:0]  m_used;
  bit         m_seen;
  int         m_waited;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk or chk_ev);
    while (sb.size() > 0 && (sb[0].now || sb[0].cyc <= cyc)) begin
      mon_e = sb.pop_front();
      if (!mon_e.now && mon_e.cyc != cyc) begin
        tests++; fails++;
        $display("FAIL stale record: cycle %0d expectation unchecked at cycle %0d", mon_e.cyc, cyc);
      end else begin
        chk("gameEnd",        40'(gameEnd),        40'(mon_e.ge));
        chk("toggle_state",   40'(toggle_state),   40'(mon_e.tg));
        chk("timeout_err",    40'(timeout_err),    40'(mon_e.te));
        chk("reject",         40'(reject),         40'(mon_e.rj));
        chk("guess",          40'(guess),          40'(mon_e.guess));
        chk("setWord",        setWord,             mon_e.word);
        chk("letters_loaded", 40'(letters_loaded), 40'(mon_e.nl));
        chk("phase",          40'(phase),          40'(mon_e.ph));
      end
    end
  end

  function automatic logic [7:0] fold(input logic [7:0] k);
    return (k >= 8'h61 && k <= 8'h7A) ? k - 8'h20 : k;
  endfunction

  function automatic logic [7:0] rand_letter();
    logic [7:0] b;
    b = 8'($urandom_range(65, 90));
    if ($urandom % 2 == 1) b = b + 8'h20;
    return b;
  endfunction

  task automatic model_reset();
    m_ph = P_LOAD; m_word.delete(); m_guess = '0; m_used = '0; m_seen = 0; m_waited = 0;
  endtask

  task automatic model(input bit kv, input logic [7:0] kd, input bit ws, input bit ng,
                       output exp_t e);
    logic [7:0] k;
    bit         ok, rep;
    logic [39:0] w;
    e = '{default: 0};
    k  = fold(kd);
    ok = (k >= 8'h41 && k <= 8'h5A);
    if (ng) begin
      e.ge = (m_ph != P_LOAD);
      model_reset();
    end else begin
      case (m_ph)
        P_LOAD:
          if (kv) begin
            if (ok && m_word.size() < 5) m_word.push_back(byte'(k));
            else e.rj = 1;
          end else if (ws) begin
            if (m_word.size() == 5) m_ph = P_ARM;
            else e.rj = 1;
          end
        P_ARM:
          if (e_rdy) begin e.tg = 1; m_ph = P_PLAY; end
          else e.rj = kv;
        P_PLAY:
          if (kv) begin
`ifdef GUESS_HISTORY_EN
            rep = ok && m_used[int'(k) - 65];
`else
            rep = ok && (k == m_guess);
`endif
            if (ok && !rep && e_rdy) begin
              m_guess = k; m_used[int'(k) - 65] = 1'b1;
              m_ph = P_WAIT; m_seen = 0; m_waited = 0;
            end else e.rj = 1;
          end
        P_WAIT: begin
          if (m_seen && e_rdy) begin
            m_ph = (e_cor == 3'd5 || e_inc == 3'd6) ? P_DONE : P_PLAY;
          end else begin
            m_waited++;
            if (m_waited == TIMEOUT) begin e.te = 1; m_ph = P_PLAY; end
          end
          if (kv && !e.te) e.rj = 1;
          if (e_busy) m_seen = 1;
        end
        default: e.rj = kv;
      endcase
    end
    w = '0;
    for (int i = 0; i < m_word.size(); i++)
      w = w + (40'(m_word[i]) << (8 * (m_word.size() - 1 - i)));
    e.guess = m_guess;
    e.word  = w;
    e.nl    = 3'(m_word.size());
    e.ph    = 3'(m_ph);
  endtask

  task automatic drive(input bit kv, input logic [7:0] kd, input bit ws, input bit ng);
    exp_t e;
    @(negedge clk);
    key_valid = kv; key_data = kd; word_submit = ws; new_game = ng;
    game_rdy = e_rdy; red_busy = e_busy; correct = e_cor; incorrect = e_inc;
    model(kv, kd, ws, ng, e);
    e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 8'h00, 0, 0);
  endtask

  task automatic key(input logic [7:0] k);
    drive(1, k, 0, 0);
  endtask

  task automatic handshake(input int busy_cycles, input logic [2:0] cor, input logic [2:0] inc);
    e_rdy = 0; e_busy = 1;
    idle(busy_cycles);
    e_busy = 0; e_cor = cor; e_inc = inc; e_rdy = 1;
    idle(1);
  endtask

  task automatic check_reset_now();
    exp_t e;
    e = '{default: 0};
    e.now = 1;
    sb.push_back(e);
    -> chk_ev;
  endtask

  task automatic async_reset();
    @(negedge clk); #1;
    key_valid = 0; word_submit = 0; new_game = 0; game_rdy = 0; red_busy = 0;
    rst = 1; #1;
    check_reset_now();
    model_reset();
    e_rdy = 0; e_busy = 0; e_cor = '0; e_inc = '0;
    @(posedge clk); @(negedge clk);
    rst = 0;
  endtask

  initial begin
    logic [7:0] six [6];
    six = '{8'h46, 8'h47, 8'h4A, 8'h4D, 8'h4E, 8'h50};
    model_reset();
    #1 rst = 1;
    #1 check_reset_now();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;

    // lowercase fold, invalid key, clear in LOAD, short submit, full word, start
    key(8'h61); key(8'h31);
    drive(0, 8'h00, 0, 1);
    key(8'h48); key(8'h45); key(8'h4C); key(8'h4C);
    drive(0, 8'h00, 1, 0);
    key(8'h4F);
    key(8'h58);
    drive(1, 8'h5A, 1, 0);
    drive(0, 8'h00, 1, 0);
    idle(2);
    key(8'h51);
    e_rdy = 1;
    idle(1);

    // guess, busy handshake, repeat and blocked keys
    key(8'h65);
    handshake(5, 3'd0, 3'd1);
    key(8'h45);
    e_rdy = 0; key(8'h4B);
    e_rdy = 1; key(8'h35);

    // A, B, A: third A is a repeat only with history enabled
    key(8'h41); handshake(3, 3'd1, 3'd1);
    key(8'h42); handshake(2, 3'd1, 3'd2);
    key(8'h41); handshake(1, 3'd1, 3'd2);

    // engine never goes busy: timeout
    key(8'h54);
    e_busy = 0; e_rdy = 1;
    for (int i = 0; i < TIMEOUT + 3; i++) drive(i == 10, 8'h5A, 0, 0);

    // miss count climbs to 6 -> DONE, then restart
    for (int i = 0; i < 6; i++) begin
      key(($urandom % 2 == 1) ? six[i] + 8'h20 : six[i]);
      handshake($urandom_range(1, 4), 3'd0, 3'(i + 1));
    end
    key(rand_letter());
    drive(0, 8'h00, 0, 1);
    idle(1);
    e_inc = '0;

    // randomized traffic
    for (int i = 0; i < 1200; i++) begin
      e_rdy  = ($urandom % 4) != 0;
      e_busy = ($urandom % 3) == 0;
      e_cor  = ($urandom % 10 == 0) ? 3'd5 : 3'($urandom % 5);
      e_inc  = ($urandom % 10 == 0) ? 3'd6 : 3'($urandom % 6);
      drive(($urandom % 3) == 0,
            ($urandom % 10 < 7) ? rand_letter() : 8'($urandom),
            ($urandom % 8) == 0,
            ($urandom % 60) == 0);
    end

    // reset asserted mid-WAIT
    e_cor = '0; e_inc = '0; e_busy = 0; e_rdy = 0;
    drive(0, 8'h00, 0, 1);
    repeat (5) key(rand_letter());
    drive(0, 8'h00, 1, 0);
    e_rdy = 1; idle(1);
    key(rand_letter());
    idle(3);
    async_reset();
    key(8'h61); key(8'h7A);
    idle(1);

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
